audio_frame_ctrl: RTL and testbench
===================================

AUDIO_FRAME_CTRL -- requirements
Module: audio_frame_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 100, meaning samples per frame (N >= 2).
REQ-002 The block SHALL have parameter W, default 32, meaning signed sample width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an upstream sample is offered.
REQ-006 The block SHALL have port in_sample, input, W signed, meaning the offered sample.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-008 The block SHALL have port raw_audio, output, N x W signed unpacked array, meaning the frame presented to audio_min_max.
REQ-009 The block SHALL have port mm_reset, output, 1, meaning the reset pulse to audio_min_max.
REQ-010 The block SHALL have port start, output, 1, meaning the start pulse to audio_min_max.
REQ-011 The block SHALL have port d, input, 1, meaning done from audio_min_max.
REQ-012 The block SHALL have ports out_max and out_min, input, W signed each, meaning audio_min_max results.
REQ-013 The block SHALL have ports frame_max and frame_min, output, W signed each, meaning captured results.
REQ-014 The block SHALL have port frame_valid, output, 1, meaning a one-cycle pulse when new results are captured.
REQ-015 The block SHALL have port frame_count, output, 16, meaning completed frames modulo 2^16.

Function
REQ-016 The FSM SHALL have the states FILL, CLR, START and BUSY.
REQ-017 In FILL: in_ready=1; an accept (in_valid && in_ready) SHALL write in_sample to raw_audio[wr_ptr] and increment wr_ptr; in_valid low SHALL leave all state unchanged.
REQ-018 An accept with wr_ptr==N-1 SHALL wrap wr_ptr to 0 and move FILL->CLR.
REQ-019 CLR SHALL last exactly one cycle with mm_reset=1 and in_ready=0, then move to START.
REQ-020 START SHALL last exactly one cycle with start=1 and in_ready=0, then move to BUSY.
REQ-021 In BUSY: in_ready=0 and raw_audio SHALL be held stable; d is sampled only in BUSY.
REQ-022 d is ignored in FILL, CLR and START; a stale d from the previous frame SHALL NOT cause a capture.
REQ-023 On the first BUSY cycle with d=1, the block SHALL register out_max/out_min into frame_max/frame_min, pulse frame_valid for one cycle, increment frame_count and return to FILL.
REQ-024 Frame latency SHALL be: the start pulse occurs exactly 2 cycles after the edge accepting sample N-1.
REQ-025 in_ready SHALL be 1 in the first FILL cycle after BUSY, so the next frame may start with zero gap.
REQ-026 frame_count SHALL wrap from 65535 to 0.
REQ-027 All outputs SHALL be registered except in_ready, which is decoded from state.
REQ-028 Samples SHALL be stored verbatim; no arithmetic or width conversion is applied.

Reset
REQ-029 Asserting reset SHALL immediately force state=FILL, wr_ptr=0, every raw_audio entry=0, frame_max=0, frame_min=0, frame_count=0, and mm_reset, start and frame_valid=0; in_ready SHALL be 1 after release.
REQ-030 Reset mid-fill or mid-BUSY SHALL discard the partial frame with no frame_valid pulse.

Structure
REQ-031 A shared package audio_pkg SHALL hold N_SAMPLES=100, SAMPLE_W=32, the sample type, and the state enumeration.
REQ-032 The frame storage SHALL be one sub-module, audio_frame_store (write port plus parallel read-out); the FSM, pointer and result capture SHALL live in audio_frame_ctrl.

Verification
REQ-033 Ramp: feed 0..99 back-to-back -> raw_audio[i]=i; mm_reset 1 cycle, then start 1 cycle, 2 cycles after the 100th accept; with a real audio_min_max: frame_min=0, frame_max=99, one frame_valid pulse, frame_count=1.
REQ-034 Backpressure: hold in_valid=1 with 150 samples -> in_ready=0 from CLR through BUSY; sample 100 lands in raw_audio[0] of the next frame; no sample is lost or duplicated.
REQ-035 Gapped input: 42 with in_valid toggling every other cycle -> exactly 100 accepts; frame_min=frame_max=42.
REQ-036 Back-to-back frames: alternating -100/+100 followed by $random -> two frame_valid pulses; first frame gives -100/100; frame_count=2; a stub holding d=1 from the previous frame through CLR/START causes no extra capture.
REQ-037 Reset after 50 accepts -> wr_ptr=0 and all outputs are at reset values; the next 100 accepts form a full frame.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sizes, sample type and FSM states for the audio frame controller
package audio_pkg;
    localparam int N_SAMPLES = 100;
    localparam int SAMPLE_W  = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_CLR,
        ST_START,
        ST_BUSY
    } state_t;
endpackage

// File: rtl/audio_frame_store.sv
// rtl/audio_frame_store.sv - frame sample storage, single write port and full parallel read-out
module audio_frame_store
    import audio_pkg::*;
#(
    parameter int N  = N_SAMPLES,
    parameter int W  = SAMPLE_W,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [W-1:0] wdata,
    output logic signed [W-1:0] rdata [N]
);
    logic signed [W-1:0] mem_q [N];
    logic signed [W-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q;
endmodule

// File: rtl/audio_frame_ctrl.sv
// rtl/audio_frame_ctrl.sv - collects N samples into a frame, sequences audio_min_max and captures its results
module audio_frame_ctrl
    import audio_pkg::*;
#(
    parameter int N = N_SAMPLES,
    parameter int W = SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_sample,
    output logic                in_ready,
    output logic signed [W-1:0] raw_audio [N],
    output logic                mm_reset,
    output logic                start,
    input  logic                d,
    input  logic signed [W-1:0] out_max,
    input  logic signed [W-1:0] out_min,
    output logic signed [W-1:0] frame_max,
    output logic signed [W-1:0] frame_min,
    output logic                frame_valid,
    output logic [15:0]         frame_count
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic                mm_reset_q, mm_reset_d;
    logic                start_q, start_d;
    logic                frame_valid_q, frame_valid_d;
    logic signed [W-1:0] frame_max_q, frame_max_d;
    logic signed [W-1:0] frame_min_q, frame_min_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                accept;
    logic                capture;

    assign in_ready = (state_q == ST_FILL);
    assign accept   = in_valid && in_ready;
    // While start is still on the wire, d can only be left over from the previous frame.
    assign capture  = (state_q == ST_BUSY) && d && !start_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        frame_max_d   = frame_max_q;
        frame_min_d   = frame_min_q;
        frame_count_d = frame_count_q;
        frame_valid_d = 1'b0;
        mm_reset_d    = (state_q == ST_CLR);
        start_d       = (state_q == ST_START);
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (wr_ptr_q == AW'(N - 1)) begin
                        wr_ptr_d = '0;
                        state_d  = ST_CLR;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_CLR:   state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (capture) begin
                    frame_max_d   = out_max;
                    frame_min_d   = out_min;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_FILL;
                end
            end
            default:  state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FILL;
            wr_ptr_q      <= '0;
            mm_reset_q    <= 1'b0;
            start_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_max_q   <= '0;
            frame_min_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            mm_reset_q    <= mm_reset_d;
            start_q       <= start_d;
            frame_valid_q <= frame_valid_d;
            frame_max_q   <= frame_max_d;
            frame_min_q   <= frame_min_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign mm_reset    = mm_reset_q;
    assign start       = start_q;
    assign frame_valid = frame_valid_q;
    assign frame_max   = frame_max_q;
    assign frame_min   = frame_min_q;
    assign frame_count = frame_count_q;

    audio_frame_store #(.N(N), .W(W), .AW(AW)) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (in_sample),
        .rdata (raw_audio)
    );
endmodule

// File: tb/tb_audio_frame_ctrl.sv
// tb/tb_audio_frame_ctrl.sv - randomized self-checking bench with a frame-level reference model
module tb_audio_frame_ctrl;
    localparam int N = 100;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_sample = '0;
    logic                in_ready;
    logic signed [W-1:0] raw_audio [N];
    logic                mm_reset, start;
    logic                d = 1'b0;
    logic signed [W-1:0] out_max = '0, out_min = '0;
    logic signed [W-1:0] frame_max, frame_min;
    logic                frame_valid;
    logic [15:0]         frame_count;

    int n_chk = 0;
    int n_err = 0;

    audio_frame_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(in_ready), .raw_audio(raw_audio), .mm_reset(mm_reset), .start(start),
        .d(d), .out_max(out_max), .out_min(out_min), .frame_max(frame_max),
        .frame_min(frame_min), .frame_valid(frame_valid), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural audio_min_max: answers a random number of cycles after start.
    bit stale_mode = 0;
    bit mm_busy = 0;
    int mm_lat = 0;
    always @(posedge clk) begin
        #2;
        if (reset) begin
            d = 0; mm_busy = 0;
        end else begin
            if (mm_reset && !stale_mode) d = 0;
            if (start) begin
                d = 0; mm_busy = 1; mm_lat = $urandom_range(1, 6);
            end else if (mm_busy) begin
                mm_lat--;
                if (mm_lat == 0) begin
                    out_max = raw_audio[0]; out_min = raw_audio[0];
                    foreach (raw_audio[i]) begin
                        if (raw_audio[i] > out_max) out_max = raw_audio[i];
                        if (raw_audio[i] < out_min) out_min = raw_audio[i];
                    end
                    d = 1; mm_busy = 0;
                end
            end
        end
    end

    // Reference model: frame contents, fill/sequence phase, captured results.
    logic signed [W-1:0] m_frame [N];
    bit          m_fill = 1;
    int          m_cnt = 0;
    int          m_e = 0;      // edges since the frame-completing accept
    bit          m_fv = 0;
    logic signed [W-1:0] m_max = 0, m_min = 0;
    logic [15:0] m_count = 0;
    int          fv_seen = 0;
    logic signed [W-1:0] res_max [$];
    logic signed [W-1:0] res_min [$];

    always @(negedge clk) begin
        int bad;
        if (reset) begin
            foreach (m_frame[i]) m_frame[i] = 0;
            m_fill = 1; m_cnt = 0; m_e = 0; m_fv = 0;
            m_max = 0; m_min = 0; m_count = 0;
        end
        chk("in_ready", in_ready, m_fill);
        chk("mm_reset", mm_reset, !m_fill && m_e == 2);
        chk("start", start, !m_fill && m_e == 3);
        chk("frame_valid", frame_valid, m_fv);
        chk("frame_max", frame_max, m_max);
        chk("frame_min", frame_min, m_min);
        chk("frame_count", frame_count, m_count);
        bad = -1;
        foreach (raw_audio[i]) if (bad < 0 && raw_audio[i] !== m_frame[i]) bad = i;
        chk("raw_audio_first_bad_index", bad, -1);
        if (frame_valid) begin
            fv_seen++; res_max.push_back(frame_max); res_min.push_back(frame_min);
        end
        if (!reset) begin
            m_fv = 0;
            if (m_fill) begin
                if (in_valid) begin
                    m_frame[m_cnt] = in_sample;
                    m_cnt++;
                    if (m_cnt == N) begin m_cnt = 0; m_fill = 0; m_e = 1; end
                end
            end else if (m_e >= 4 && d) begin
                m_max = m_frame[0]; m_min = m_frame[0];
                foreach (m_frame[i]) begin
                    if (m_frame[i] > m_max) m_max = m_frame[i];
                    if (m_frame[i] < m_min) m_min = m_frame[i];
                end
                m_fv = 1; m_count++; m_fill = 1; m_e = 0;
            end else begin
                m_e++;
            end
        end
    end

    task automatic send(input logic signed [W-1:0] v);
        bit acc = 0;
        in_valid = 1; in_sample = v;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic wait_fv(input int target);
        int k = 0;
        while (fv_seen < target && k < 400) begin @(posedge clk); #1; k++; end
        chk("frame_valid_timeout", fv_seen >= target, 1);
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; in_valid = 0;
        repeat (2) @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_count", frame_count, 0);
        @(posedge clk); #1;

        // Ramp with pinned latency of mm_reset/start after the 100th accept
        for (int i = 0; i < N; i++) send(i);
        @(negedge clk); chk("ramp_e1_mm", mm_reset, 0); chk("ramp_e1_st", start, 0);
        @(negedge clk); chk("ramp_e2_mm", mm_reset, 1); chk("ramp_e2_st", start, 0);
        @(negedge clk); chk("ramp_e3_mm", mm_reset, 0); chk("ramp_e3_st", start, 1);
        chk("ramp_raw99", raw_audio[99], 99);
        wait_fv(1);
        chk("ramp_min", res_min[0], 0);
        chk("ramp_max", res_max[0], 99);
        chk("ramp_count", frame_count, 1);

        // Backpressure: 150 samples offered continuously
        for (int i = 0; i < 150; i++) send($signed($urandom()));
        wait_fv(2);
        chk("bp_wrapped_slot", raw_audio[49], m_frame[49]);
        for (int i = 0; i < 50; i++) send($signed($urandom()));
        wait_fv(3);

        // Gapped constant input
        for (int i = 0; i < N; i++) begin
            send(42);
            @(posedge clk); #1;
        end
        wait_fv(4);
        chk("gap_max", res_max[3], 42);
        chk("gap_min", res_min[3], 42);

        // Back-to-back frames with a done that lingers into CLR/START
        do_reset();
        stale_mode = 1;
        for (int i = 0; i < N; i++) send((i % 2) ? 100 : -100);
        for (int i = 0; i < N; i++) send($signed($urandom()));
        wait_fv(6);
        repeat (20) @(posedge clk); #1;
        chk("b2b_pulses", fv_seen, 6);
        chk("b2b_max", res_max[4], 100);
        chk("b2b_min", res_min[4], -100);
        chk("b2b_count", frame_count, 2);
        stale_mode = 0;

        // Reset mid-fill discards the partial frame
        for (int i = 0; i < 50; i++) send(i + 1000);
        do_reset();
        @(negedge clk);
        chk("midrst_count", frame_count, 0);
        chk("midrst_raw0", raw_audio[0], 0);
        chk("midrst_max", frame_max, 0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) send(-i);
        wait_fv(7);
        chk("midrst_frame_max", res_max[6], 0);
        chk("midrst_frame_min", res_min[6], -99);
        chk("midrst_frame_count", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
